linear_layer_host: RTL and testbench



---
 rtl/linear_layer_host.sv | 218 +++++++++++++++++++++
 tb/tb_linear_layer_host.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_host.sv
// Host-side sequencer for linear_layer_unit: loads operands from a serial stream,
// starts the unit, waits for done (with timeout) and drains the result matrix.
module linear_layer_host #(
    parameter int DATA_WIDTH     = 8,
    parameter int ACCUM_WIDTH    = 32,
    parameter int M_ROWS         = 2,
    parameter int K_COLS         = 2,
    parameter int N_COLS         = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cmd_start,
    output logic                                  cmd_busy,
    output logic                                  cmd_done,
    output logic                                  cmd_error,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ACCUM_WIDTH-1:0]                in_data,
    output logic [M_ROWS*K_COLS*DATA_WIDTH-1:0]   ll_act,
    output logic [K_COLS*N_COLS*DATA_WIDTH-1:0]   ll_wgt,
    output logic [N_COLS*ACCUM_WIDTH-1:0]         ll_bias,
    output logic                                  ll_start,
    input  logic                                  ll_busy,
    input  logic                                  ll_done,
    input  logic [M_ROWS*N_COLS*ACCUM_WIDTH-1:0]  ll_result,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ACCUM_WIDTH-1:0]                out_data,
    output logic                                  out_last
);

    localparam int NUM_ACT    = M_ROWS * K_COLS;
    localparam int NUM_WGT    = K_COLS * N_COLS;
    localparam int NUM_BIAS   = N_COLS;
    localparam int LOAD_BEATS = NUM_ACT + NUM_WGT + NUM_BIAS;
    localparam int NUM_OUT    = M_ROWS * N_COLS;
    localparam int BEAT_W     = $clog2(LOAD_BEATS + 1);
    localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W      = $clog2(NUM_OUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_DRAIN,
        ST_FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [BEAT_W-1:0]                     beat_cnt;
    logic [TO_W-1:0]                       wait_cnt;
    logic [IDX_W-1:0]                      out_idx;
    logic [M_ROWS*N_COLS*ACCUM_WIDTH-1:0]  result_buf;

    logic beat_fire;
    logic out_fire;
    logic last_beat;
    logic timed_out;
    logic last_out;

    // ll_busy is informational; the sequencer relies solely on ll_done.
    logic unused_ll_busy;
    assign unused_ll_busy = ll_busy;

    assign beat_fire = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_beat = (beat_cnt == BEAT_W'(LOAD_BEATS - 1));
    assign timed_out = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign last_out  = (out_idx == IDX_W'(NUM_OUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_busy   = 1'b1;
        cmd_done   = 1'b0;
        in_ready   = 1'b0;
        ll_start   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_busy = 1'b0;
                if (cmd_start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (beat_fire && last_beat) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                ll_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (ll_done) begin
                    state_next = ST_CAPTURE;
                end else if (timed_out) begin
                    state_next = ST_FIN;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_last  = last_out;
                if (out_fire && last_out) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                cmd_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Beat, timeout and drain counters plus the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            out_idx    <= '0;
            cmd_error  <= 1'b0;
            result_buf <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        beat_cnt  <= '0;
                        cmd_error <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                ST_START: begin
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (!ll_done) begin
                        if (timed_out) begin
                            cmd_error <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    result_buf <= ll_result;
                    out_idx    <= '0;
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        out_idx <= out_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Beat position selects the operand register; a/w keep only the low byte lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ll_act  <= '0;
            ll_wgt  <= '0;
            ll_bias <= '0;
        end else if (beat_fire) begin
            for (int i = 0; i < NUM_ACT; i++) begin
                if (int'(beat_cnt) == i) begin
                    ll_act[i*DATA_WIDTH +: DATA_WIDTH] <= in_data[DATA_WIDTH-1:0];
                end
            end
            for (int i = 0; i < NUM_WGT; i++) begin
                if (int'(beat_cnt) == NUM_ACT + i) begin
                    ll_wgt[i*DATA_WIDTH +: DATA_WIDTH] <= in_data[DATA_WIDTH-1:0];
                end
            end
            for (int i = 0; i < NUM_BIAS; i++) begin
                if (int'(beat_cnt) == NUM_ACT + NUM_WGT + i) begin
                    ll_bias[i*ACCUM_WIDTH +: ACCUM_WIDTH] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (int'(out_idx) == i) begin
                out_data = result_buf[i*ACCUM_WIDTH +: ACCUM_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_linear_layer_host.sv
// Self-checking bench for linear_layer_host with a behavioural linear-unit stub
// (configurable done latency, or never done) and a scoreboard of expected beats.
module tb_linear_layer_host;

    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int M    = 2;
    localparam int K    = 2;
    localparam int N    = 2;
    localparam int TO   = 16;
    localparam int L    = M*K + K*N + N;
    localparam int NOUT = M*N;
    localparam int LAT  = 3;
    localparam int NVEC = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_start = 1'b0;
    logic              cmd_busy, cmd_done, cmd_error;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [AW-1:0]     in_data = '0;
    logic [M*K*DW-1:0] ll_act;
    logic [K*N*DW-1:0] ll_wgt;
    logic [N*AW-1:0]   ll_bias;
    logic              ll_start;
    logic              ll_busy;
    logic              ll_done;
    logic [NOUT*AW-1:0] ll_result;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [AW-1:0]     out_data;
    logic              out_last;

    linear_layer_host #(
        .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .M_ROWS(M), .K_COLS(K), .N_COLS(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_busy(cmd_busy),
        .cmd_done(cmd_done), .cmd_error(cmd_error), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .ll_act(ll_act), .ll_wgt(ll_wgt),
        .ll_bias(ll_bias), .ll_start(ll_start), .ll_busy(ll_busy), .ll_done(ll_done),
        .ll_result(ll_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Linear unit stub: result = act x wgt + bias, done LAT cycles after start.
    logic [NOUT*AW-1:0] model_res;
    logic [NOUT*AW-1:0] stub_res = '0;
    int                 stub_cnt = 0;
    int                 start_pulses = 0;
    bit                 stub_hang = 1'b0;
    logic               inject_done = 1'b0;
    int                 acc;
    byte                ea, eb;

    always_comb begin
        model_res = '0;
        acc = 0;
        ea = 0;
        eb = 0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                acc = ll_bias[n*AW +: AW];
                for (int k = 0; k < K; k++) begin
                    ea = ll_act[(m*K+k)*DW +: DW];
                    eb = ll_wgt[(k*N+n)*DW +: DW];
                    acc = acc + int'(ea) * int'(eb);
                end
                model_res[(m*N+n)*AW +: AW] = acc;
            end
        end
    end

    always @(posedge clk) begin
        if (ll_start) begin
            start_pulses <= start_pulses + 1;
            stub_cnt     <= LAT;
            stub_res     <= model_res;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    assign ll_result = stub_res;
    assign ll_busy   = (stub_cnt != 0);
    assign ll_done   = ((stub_cnt == 1) && !stub_hang) || inject_done;

    typedef struct {
        logic [AW-1:0] beats [L];
        logic [AW-1:0] exp   [NOUT];
        bit            gaps;
        bit            bp;
        bit            poke;
        bit            hang;
        int            rst_after;
    } vec_t;

    vec_t          vecs [NVEC];
    logic [AW-1:0] nom_b [L];
    logic [AW-1:0] neg_b [L];
    logic [AW-1:0] nom_e [NOUT];
    logic [AW-1:0] neg_e [NOUT];
    logic [AW-1:0] exp_q [$];
    int            tests_run = 0;
    int            tests_failed = 0;

    task automatic checkOutput(input string what, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input bit neg, input bit gaps, input bit bp,
                                   input bit poke, input bit hang, input int ra);
        vec_t v;
        v.beats     = neg ? neg_b : nom_b;
        v.exp       = neg ? neg_e : nom_e;
        v.gaps      = gaps;
        v.bp        = bp;
        v.poke      = poke;
        v.hang      = hang;
        v.rst_after = ra;
        return v;
    endfunction

    task automatic applyStimulus(input int vi);
        vec_t             v;
        bit               hs;
        bit               prev_stall;
        logic [AW-1:0]    prev_data;
        logic             prev_last;
        logic [AW-1:0]    e;
        logic [M*K*DW-1:0] exp_act;
        logic [K*N*DW-1:0] exp_wgt;
        logic [N*AW-1:0]  exp_bias;
        int guard, n, done_n, lld_n, fv_n, lb_n, popped, pulses0;

        v         = vecs[vi];
        stub_hang = v.hang;
        pulses0   = start_pulses;
        if (!v.hang) begin
            for (int i = 0; i < NOUT; i++) exp_q.push_back(v.exp[i]);
        end
        for (int i = 0; i < M*K; i++) exp_act[i*DW +: DW] = v.beats[i][DW-1:0];
        for (int i = 0; i < K*N; i++) exp_wgt[i*DW +: DW] = v.beats[M*K+i][DW-1:0];
        for (int i = 0; i < N; i++)   exp_bias[i*AW +: AW] = v.beats[M*K+K*N+i];

        in_valid  = !v.gaps;
        in_data   = v.beats[0];
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;

        for (int b = 0; b < L; b++) begin
            if (v.gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
            end
            in_valid    = 1'b1;
            in_data     = v.beats[b];
            inject_done = v.poke && (b == 4);
            guard = 0;
            do begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk); #1;
                inject_done = 1'b0;
                guard++;
            end while (!hs && guard < 50);
            if (!hs) begin
                checkOutput($sformatf("v%0d load handshake timeout", vi), 64'(0), 64'(1));
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = '0;

        @(negedge clk);
        checkOutput($sformatf("v%0d ll_start after load", vi), 64'(ll_start), 64'(1));
        checkOutput($sformatf("v%0d cmd_busy", vi), 64'(cmd_busy), 64'(1));
        checkOutput($sformatf("v%0d cmd_error cleared", vi), 64'(cmd_error), 64'(0));
        checkOutput($sformatf("v%0d ll_act", vi), 64'(ll_act), 64'(exp_act));
        checkOutput($sformatf("v%0d ll_wgt", vi), 64'(ll_wgt), 64'(exp_wgt));
        checkOutput($sformatf("v%0d ll_bias", vi), 64'(ll_bias), 64'(exp_bias));
        @(posedge clk); #1;

        n = 0; done_n = -1; lld_n = -1; fv_n = -1; lb_n = -1; popped = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        while (done_n < 0 && n < 200) begin
            cmd_start = v.poke && (n == 0 || (fv_n >= 0 && n == fv_n + 1));
            out_ready = v.bp ? ($urandom_range(1, 0) == 1) : 1'b1;
            @(negedge clk);
            if (ll_done && lld_n < 0) lld_n = n;
            if (out_valid && fv_n < 0) fv_n = n;
            if (prev_stall) begin
                checkOutput($sformatf("v%0d out_data held", vi), 64'(out_data), 64'(prev_data));
                checkOutput($sformatf("v%0d out_last held", vi), 64'(out_last), 64'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput($sformatf("v%0d unexpected beat", vi), 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    checkOutput($sformatf("v%0d out_data beat %0d", vi, popped), 64'(out_data), 64'(e));
                    checkOutput($sformatf("v%0d out_last beat %0d", vi, popped), 64'(out_last),
                                64'(popped == NOUT));
                end
                lb_n = n;
            end
            if (cmd_done) begin
                done_n = n;
                checkOutput($sformatf("v%0d cmd_error at done", vi), 64'(cmd_error), 64'(v.hang));
            end
            @(posedge clk); #1;
            n++;
            if (v.rst_after != 0 && popped == v.rst_after) begin
                cmd_start = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                @(negedge clk);
                checkOutput($sformatf("v%0d ctrl after reset", vi),
                            64'({cmd_busy, cmd_done, cmd_error, in_ready, ll_start, out_valid, out_last}),
                            64'(0));
                checkOutput($sformatf("v%0d out_data after reset", vi), 64'(out_data), 64'(0));
                checkOutput($sformatf("v%0d operands after reset", vi),
                            64'(ll_act) | 64'(ll_wgt) | 64'(ll_bias), 64'(0));
                @(posedge clk); #1;
                rst_n = 1'b1;
                checkOutput($sformatf("v%0d ll_start pulses", vi), 64'(start_pulses - pulses0), 64'(1));
                exp_q.delete();
                return;
            end
        end
        cmd_start = 1'b0;

        if (done_n < 0) begin
            checkOutput($sformatf("v%0d cmd_done timeout", vi), 64'(0), 64'(1));
        end else if (v.hang) begin
            checkOutput($sformatf("v%0d done cycles after ll_start-1", vi), 64'(done_n), 64'(TO));
            checkOutput($sformatf("v%0d no out_valid", vi), 64'(fv_n < 0), 64'(1));
        end else begin
            checkOutput($sformatf("v%0d first out_valid vs done", vi), 64'(fv_n), 64'(lld_n + 2));
            checkOutput($sformatf("v%0d cmd_done after last beat", vi), 64'(done_n), 64'(lb_n + 1));
            checkOutput($sformatf("v%0d beats drained", vi), 64'(popped), 64'(NOUT));
        end
        @(negedge clk);
        checkOutput($sformatf("v%0d single done pulse", vi), 64'({cmd_done, cmd_busy}), 64'(0));
        checkOutput($sformatf("v%0d ll_start pulses", vi), 64'(start_pulses - pulses0), 64'(1));
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        nom_b = '{32'd1, 32'd2, 32'd3, 32'd1, 32'd3, 32'd4, 32'd5, 32'd6, 32'd10, 32'd20};
        neg_b = '{32'hFFFFFFFF, 32'd2, 32'd3, 32'hFFFFFFFF, 32'd3, 32'd4, 32'd5, 32'd6, 32'd10, 32'd20};
        nom_e = '{32'd23, 32'd36, 32'd24, 32'd38};
        neg_e = '{32'd17, 32'd28, 32'd14, 32'd26};
        //               neg  gaps bp   poke hang rst
        vecs[0] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        vecs[1] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        vecs[2] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        vecs[3] = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        vecs[4] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        vecs[5] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        vecs[6] = mkVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset ctrl outputs",
                    64'({cmd_busy, cmd_done, cmd_error, in_ready, ll_start, out_valid, out_last}), 64'(0));
        checkOutput("reset out_data", 64'(out_data), 64'(0));
        checkOutput("reset operands", 64'(ll_act) | 64'(ll_wgt) | 64'(ll_bias), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int vi = 0; vi < NVEC; vi++) begin
            applyStimulus(vi);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
